// File: rtl/game_pkg.sv
// Shared game definitions: action bit indices, action masks, encoder states,
// and the fixed action priority used by the player action encoder.
package game_pkg;

  localparam int ACT_WIDTH = 6;

  // Bit positions inside the action word {J,MR,ML,W,P,K}
  localparam int ACT_J  = 5;
  localparam int ACT_MR = 4;
  localparam int ACT_ML = 3;
  localparam int ACT_W  = 2;
  localparam int ACT_P  = 1;
  localparam int ACT_K  = 0;

  typedef logic [ACT_WIDTH-1:0] action_t;

  localparam action_t ONEHOT_J  = action_t'(1) << ACT_J;
  localparam action_t ONEHOT_MR = action_t'(1) << ACT_MR;
  localparam action_t ONEHOT_ML = action_t'(1) << ACT_ML;
  localparam action_t ONEHOT_W  = action_t'(1) << ACT_W;
  localparam action_t ONEHOT_P  = action_t'(1) << ACT_P;
  localparam action_t ONEHOT_K  = action_t'(1) << ACT_K;

  // Press-triggered actions, held-level actions, attacks, and wait aborters
  localparam action_t MASK_EDGE   = ONEHOT_J | ONEHOT_W | ONEHOT_P | ONEHOT_K;
  localparam action_t MASK_LEVEL  = ONEHOT_MR | ONEHOT_ML;
  localparam action_t MASK_ATTACK = ONEHOT_P | ONEHOT_K;
  localparam action_t MASK_ABORT  = ONEHOT_J | ONEHOT_P | ONEHOT_K;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT2    = 2'd1,
    COOLDOWN = 2'd2
  } enc_state_t;

  // Highest-priority candidate as a one-hot word: J > P > K > W > MR > ML
  function automatic action_t pick_first(input action_t cand);
    action_t res;
    res = '0;
    if (cand[ACT_J])       res = ONEHOT_J;
    else if (cand[ACT_P])  res = ONEHOT_P;
    else if (cand[ACT_K])  res = ONEHOT_K;
    else if (cand[ACT_W])  res = ONEHOT_W;
    else if (cand[ACT_MR]) res = ONEHOT_MR;
    else if (cand[ACT_ML]) res = ONEHOT_ML;
    return res;
  endfunction

endpackage

// File: rtl/player_action_encoder_btn_debounce.sv
// One button channel: two-flop synchroniser, consecutive-sample debounce
// counter, debounced level, and a one-cycle pulse when the level rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam logic [3:0] LP_TARGET = 4'(DEBOUNCE_CYCLES);

  logic       r_sync0;
  logic       r_sync1;
  logic [3:0] r_cnt;
  logic       r_level;
  logic       r_rise;

  // Bring the raw button into the CLK domain
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= i_raw;
      r_sync1 <= r_sync0;
    end
  end

  // Count consecutive samples that disagree with the level; flip when the run is long enough
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt   <= 4'd0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (r_sync1 == r_level) begin
        r_cnt <= 4'd0;
      end else if (r_cnt == LP_TARGET - 4'd1) begin
        r_cnt   <= 4'd0;
        r_level <= r_sync1;
        r_rise  <= r_sync1;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/player_action_encoder.sv
// Per-player action encoder: debounces six buttons, latches press events,
// and on each game tick emits one action word chosen by priority while
// sequencing the two-tick wait and the attack cooldown.
module player_action_encoder
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_TICKS  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 tick,
  input  logic                 enable,
  input  logic [ACT_WIDTH-1:0] btn,
  output logic [ACT_WIDTH-1:0] action,
  output logic                 action_valid,
  output logic                 busy
);

  localparam logic [1:0] LP_CD = 2'(COOLDOWN_TICKS);

  logic [ACT_WIDTH-1:0] w_level;
  logic [ACT_WIDTH-1:0] w_rise;

  enc_state_t r_state;
  enc_state_t w_state_next;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_next;
  action_t    r_pend;
  action_t    w_pend_next;
  action_t    r_action;
  action_t    w_action_next;
  logic       r_valid;
  logic       w_valid_next;

  action_t w_held;
  action_t w_lvl_ok;
  action_t w_set;
  action_t w_avail;
  action_t w_cand;
  action_t w_pick;

  genvar gi;
  generate
    for (gi = 0; gi < ACT_WIDTH; gi++) begin : gen_db
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .CLK    (CLK),
        .RST    (RST),
        .i_raw  (btn[gi]),
        .o_level(w_level[gi]),
        .o_rise (w_rise[gi])
      );
    end
  endgenerate

  // Eligibility, priority pick, pending bookkeeping and next state for this cycle
  always_comb begin
    // Movement is a held level; opposing directions cancel each other
    w_held   = w_level & MASK_LEVEL;
    w_lvl_ok = (w_held == MASK_LEVEL) ? '0 : w_held;

    // New presses; a W press during the wait is discarded
    w_set = w_rise & MASK_EDGE;
    if (r_state == WAIT2) w_set = w_set & ~ONEHOT_W;
    w_avail = r_pend | w_set;

    case (r_state)
      WAIT2:    w_cand = w_avail & MASK_ABORT;
      COOLDOWN: w_cand = (w_avail & ~MASK_ATTACK) | w_lvl_ok;
      default:  w_cand = w_avail | w_lvl_ok;
    endcase

    w_pick = pick_first(w_cand);
    // Without an aborting press the wait completes with its second W
    if (r_state == WAIT2 && w_pick == '0) w_pick = ONEHOT_W;

    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_pend_next   = w_avail;
    if (r_state == WAIT2) w_pend_next = w_pend_next & ~ONEHOT_W;
    w_valid_next  = 1'b0;
    w_action_next = '0;

    if (!enable) begin
      w_pend_next  = '0;
      w_state_next = IDLE;
      w_cnt_next   = 2'd0;
    end else if (tick) begin
      w_valid_next  = 1'b1;
      w_action_next = w_pick;
      w_pend_next   = w_pend_next & ~w_pick;
      if (w_pick[ACT_W] && r_state != WAIT2) begin
        // First W of a wait, also cutting any cooldown short
        w_state_next = WAIT2;
        w_cnt_next   = 2'd0;
      end else if ((w_pick & MASK_ATTACK) != '0) begin
        if (LP_CD != 2'd0) begin
          w_state_next = COOLDOWN;
          w_cnt_next   = LP_CD;
        end else begin
          w_state_next = IDLE;
          w_cnt_next   = 2'd0;
        end
      end else if (r_state == COOLDOWN) begin
        w_cnt_next = (r_cnt == 2'd0) ? 2'd0 : r_cnt - 2'd1;
        if (r_cnt <= 2'd1) w_state_next = IDLE;
      end else begin
        w_state_next = IDLE;
      end
    end
  end

  // State, cooldown count and pending presses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pend  <= w_pend_next;
    end
  end

  // Register the tick decision so the action word appears the cycle after the tick
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_action <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_action <= w_action_next;
      r_valid  <= w_valid_next;
    end
  end

  assign action       = r_action;
  assign action_valid = r_valid;
  assign busy         = enable && (r_state != IDLE);

endmodule

// File: tb/tb_player_action_encoder.sv
// Bench for player_action_encoder: hand-derived vector table, directed
// corner sequences, and randomized buttons checked against a reference model.
module tb_player_action_encoder;

  localparam int DB = 4;
  localparam int CD = 1;

  localparam logic [5:0] B_J  = 6'b100000;
  localparam logic [5:0] B_MR = 6'b010000;
  localparam logic [5:0] B_ML = 6'b001000;
  localparam logic [5:0] B_W  = 6'b000100;
  localparam logic [5:0] B_P  = 6'b000010;
  localparam logic [5:0] B_K  = 6'b000001;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_COOL = 2;

  logic       CLK;
  logic       RST;
  logic       tick;
  logic       enable;
  logic [5:0] btn;
  logic [5:0] action;
  logic       action_valid;
  logic       busy;

  int vectors;
  int miscompares;

  player_action_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .COOLDOWN_TICKS (CD)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .tick        (tick),
    .enable      (enable),
    .btn         (btn),
    .action      (action),
    .action_valid(action_valid),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // Debounced level flips once the last DB synchronised samples all differ
  // from it; the synchronised sample at an edge is the raw value two edges back.
  logic [5:0] raw_q[$];
  logic [5:0] samp[$];
  logic [5:0] m_lvl, m_lvl_prev, m_pend, m_act;
  logic       m_valid;
  int         m_mode, m_left;

  task automatic m_reset();
    raw_q.delete();
    raw_q.push_back(6'b0);
    raw_q.push_back(6'b0);
    samp.delete();
    m_lvl = 0; m_lvl_prev = 0; m_pend = 0; m_act = 0;
    m_valid = 0; m_mode = M_IDLE; m_left = 0;
  endtask

  task automatic m_step();
    int         ord[6] = '{5, 1, 0, 2, 4, 3};
    logic [5:0] rise, setb, avail, elig, issued, smp;
    bit         was_wait;
    bit         diff;
    rise     = m_lvl & ~m_lvl_prev;
    issued   = 0;
    was_wait = (m_mode == M_WAIT);
    if (!enable) begin
      m_pend = 0; m_mode = M_IDLE; m_left = 0; m_valid = 0; m_act = 0;
    end else begin
      setb = rise & (B_J | B_W | B_P | B_K);
      if (was_wait) setb[2] = 1'b0;
      avail   = m_pend | setb;
      elig    = 0;
      elig[5] = avail[5];
      elig[1] = avail[1] && m_mode != M_COOL;
      elig[0] = avail[0] && m_mode != M_COOL;
      elig[2] = avail[2] && m_mode != M_WAIT;
      elig[4] = m_lvl[4] && !m_lvl[3] && m_mode != M_WAIT;
      elig[3] = m_lvl[3] && !m_lvl[4] && m_mode != M_WAIT;
      if (tick) begin
        for (int k = 0; k < 6; k++)
          if (elig[ord[k]] && issued == 0) issued[ord[k]] = 1'b1;
        if (issued == 0 && was_wait) issued = B_W;
        if (issued == B_W) begin
          m_mode = was_wait ? M_IDLE : M_WAIT;
          m_left = 0;
        end else if (issued == B_P || issued == B_K) begin
          m_mode = (CD > 0) ? M_COOL : M_IDLE;
          m_left = CD;
        end else if (m_mode == M_COOL) begin
          m_left = (m_left > 0) ? m_left - 1 : 0;
          if (m_left == 0) m_mode = M_IDLE;
        end else begin
          m_mode = M_IDLE;
        end
      end
      m_pend = avail & ~issued;
      if (was_wait) m_pend[2] = 1'b0;
      m_valid = tick;
      m_act   = issued;
    end
    raw_q.push_back(btn);
    smp = raw_q[0];
    void'(raw_q.pop_front());
    samp.push_back(smp);
    if (samp.size() > DB) void'(samp.pop_front());
    m_lvl_prev = m_lvl;
    if (samp.size() == DB) begin
      for (int b = 0; b < 6; b++) begin
        diff = 1'b1;
        foreach (samp[s]) if (samp[s][b] == m_lvl[b]) diff = 1'b0;
        if (diff) m_lvl[b] = ~m_lvl[b];
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) m_reset();
      else m_step();
    end
  end

  // ---------------- drivers and checkers ----------------
  task automatic step(input logic [5:0] b, input logic e, input logic t);
    logic exp_busy;
    btn = b; enable = e; tick = t;
    @(posedge CLK);
    @(negedge CLK);
    exp_busy = enable && (m_mode != M_IDLE);
    vectors++;
    if (action_valid !== m_valid || busy !== exp_busy || (m_valid && action !== m_act)) begin
      miscompares++;
      $display("FAIL model @%0t: got valid=%b action=%b busy=%b, expected valid=%b action=%b busy=%b",
               $time, action_valid, action, busy, m_valid, m_act, exp_busy);
    end
  endtask

  task automatic chk(input string name, input logic ev, input logic [5:0] ea, input logic eb);
    vectors++;
    if (action_valid !== ev || busy !== eb || (ev && action !== ea)) begin
      miscompares++;
      $display("FAIL %s: got valid=%b action=%b busy=%b, expected valid=%b action=%b busy=%b",
               name, action_valid, action, busy, ev, ea, eb);
    end
  endtask

  typedef struct {
    logic [5:0] b;
    logic       en;
    int         n;
    logic       tk;
    logic       ev;
    logic [5:0] ea;
    logic       eb;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [5:0] b, logic en, int n, logic tk, logic ev, logic [5:0] ea, logic eb);
    vec_t v;
    v.b = b; v.en = en; v.n = n; v.tk = tk; v.ev = ev; v.ea = ea; v.eb = eb;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [5:0] rb;
    logic [5:0] bb;
    logic       tk;
    int         hold[6];
    vectors = 0;
    miscompares = 0;
    RST = 1'b0; btn = 0; enable = 0; tick = 0;

    // btn, en, idle cycles, tick, exp valid, exp action, exp busy
    add(0, 1, 2, 1, 1, 0, 0);
    add(0, 1, 2, 1, 1, 0, 0);
    add(0, 1, 2, 1, 1, 0, 0);
    add(B_W, 1, 8, 1, 1, B_W, 1);                 // wait: first W
    add(B_W, 1, 2, 1, 1, B_W, 0);                 // wait: second W
    add(0, 1, 8, 1, 1, 0, 0);
    add(B_W, 1, 8, 1, 1, B_W, 1);
    add(B_W | B_K, 1, 8, 1, 1, B_K, 1);           // K aborts the wait
    add(B_W | B_K, 1, 2, 1, 1, 0, 0);             // cooldown tick
    add(0, 1, 8, 1, 1, 0, 0);
    add(B_J | B_P | B_MR, 1, 8, 1, 1, B_J, 0);    // simultaneous presses
    add(B_J | B_P | B_MR, 1, 2, 1, 1, B_P, 1);
    add(B_J | B_P | B_MR, 1, 2, 1, 1, B_MR, 0);
    add(B_J | B_P | B_MR, 1, 2, 1, 1, B_MR, 0);
    add(B_J | B_P | B_MR | B_ML, 1, 8, 1, 1, 0, 0); // both directions cancel
    add(0, 1, 8, 1, 1, 0, 0);
    add(B_P, 1, 8, 0, 0, 0, 0);                   // P pending, no tick
    add(B_P, 0, 0, 0, 0, 0, 0);                   // one cycle disabled: flush
    add(B_P, 1, 0, 1, 1, 0, 0);
    add(B_P, 1, 3, 1, 1, 0, 0);                   // held P does not retrigger
    add(0, 0, 0, 1, 0, 0, 0);                     // tick while disabled
    add(0, 1, 8, 1, 1, 0, 0);

    @(negedge CLK);
    @(negedge CLK);
    chk("reset", 1'b0, 6'b0, 1'b0);
    vectors++;
    if (action !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_action: got %b, expected 000000", action);
    end
    RST = 1'b1;

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].b, tbl[i].en, 1'b0);
      step(tbl[i].b, tbl[i].en, tbl[i].tk);
      chk($sformatf("table%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].eb);
    end

    // Bouncy P: alternating for 6 cycles, then held; only the post-debounce tick issues P
    for (int s = 1; s <= 13; s++) begin
      bb = (s <= 6) ? ((s % 2 == 1) ? B_P : 6'b0) : B_P;
      tk = (s % 3 == 0) || (s == 13);
      step(bb, 1'b1, tk);
      if (tk) chk($sformatf("bounce_s%0d", s), 1'b1, (s == 13) ? B_P : 6'b0, s == 13);
    end
    // Second P pressed during cooldown: blocked on the next tick, issued on the one after
    for (int k = 0; k < 8; k++) step(0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step(B_P, 1'b1, 1'b0);
    step(B_P, 1'b1, 1'b1);
    chk("cooldown_block", 1'b1, 6'b0, 1'b0);
    step(B_P, 1'b1, 1'b1);
    chk("cooldown_after", 1'b1, B_P, 1'b1);
    for (int k = 0; k < 8; k++) step(0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1);
    chk("cooldown_end", 1'b1, 6'b0, 1'b0);

    // Reset in the middle of a wait: outputs clear at once, no second W
    for (int k = 0; k < 8; k++) step(B_W, 1'b1, 1'b0);
    step(B_W, 1'b1, 1'b1);
    chk("wait_first_w", 1'b1, B_W, 1'b1);
    #2 RST = 1'b0;
    #1 chk("async_reset", 1'b0, 6'b0, 1'b0);
    vectors++;
    if (action !== 6'b0) begin
      miscompares++;
      $display("FAIL async_reset_action: got %b, expected 000000", action);
    end
    #1 RST = 1'b1;
    step(B_W, 1'b1, 1'b1);
    chk("after_reset_tick", 1'b1, 6'b0, 1'b0);
    for (int k = 0; k < 10; k++) step(0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1);
    chk("after_reset_quiet", 1'b1, 6'b0, 1'b0);

    // Randomized buttons with mixed short (bouncy) and long holds
    rb = 0;
    foreach (hold[b]) hold[b] = $urandom_range(1, 24);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 6; b++) begin
        if (hold[b] == 0) begin
          rb[b]   = ~rb[b];
          hold[b] = $urandom_range(1, 24);
        end else begin
          hold[b]--;
        end
      end
      step(rb, $urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
